pipe_perf_monitor: RTL and testbench

Synthesizable, parametrised pipeline performance monitor for the pipelined CPU. It counts run cycles and up to NUM_EVT per-cycle event strobes, such as stall, flush and retire, each in its own counter. It also ends a run on a programmable cycle limit or on a detected PC halt loop. It sits beside the CPU top, with its event inputs tapped from the hazard unit, the branch logic and the writeback stage. Testbenches and debug logic read its counters through a registered select port.

---
 rtl/pipe_perf_pkg.sv | 16 +
 rtl/perf_counter.sv | 52 +++++
 rtl/pipe_perf_monitor.sv | 147 ++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_pkg.sv
// Shared types for the pipeline performance monitor: FSM states and done-cause codes.
package pipe_perf_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StFrozen = 2'd2,
      StDone   = 2'd3
   } perf_state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_LIMIT = 2'b01;
   localparam logic [1:0] CAUSE_HALT  = 2'b10;
   localparam logic [1:0] CAUSE_BOTH  = 2'b11;

endpackage

// File: rtl/perf_counter.sv
// One event counter with synchronous clear, saturate-or-wrap on overflow and a sticky
// overflow flag. Exposes its next value so readout can show the post-edge count.
module perf_counter #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          SATURATE = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   assign at_max = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i) begin
         ovf_d = ovf_q | at_max;
         if (at_max) begin
            cnt_d = SATURATE ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_o = cnt_d;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: run-control FSM, cycle/event counters, PC halt-loop
// detector and a registered counter readout port.
module pipe_perf_monitor
   import pipe_perf_pkg::*;
#(
   parameter int unsigned NUM_EVT    = 4,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned HALT_LIMIT = 8,
   parameter bit          SATURATE   = 1'b1,
   localparam int unsigned SEL_W     = $clog2(NUM_EVT + 1)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               freeze_i,
   input  logic               clear_i,
   input  logic [NUM_EVT-1:0] evt_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [CNT_W-1:0]   cycle_limit_i,
   input  logic [SEL_W-1:0]   rd_sel_i,
   output logic [CNT_W-1:0]   rd_data_o,
   output logic [CNT_W-1:0]   cycle_cnt_o,
   output logic [NUM_EVT:0]   ovf_o,
   output logic               running_o,
   output logic               done_o,
   output logic [1:0]         done_cause_o
);

   localparam int unsigned NCNT = NUM_EVT + 1;
   localparam int unsigned HC_W = $clog2(HALT_LIMIT + 2);

   perf_state_e      state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [HC_W-1:0]  halt_cnt_q, halt_cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             running_q, done_q;
   logic             count_en, pc_same, limit_hit, halt_hit;
   logic [NCNT-1:0]  inc_vec;
   logic [CNT_W-1:0] cnt_cur [NCNT];
   logic [CNT_W-1:0] cnt_nxt [NCNT];

   // A RUN cycle only counts if the run is sustained and not being paused or cleared.
   assign count_en  = (state_q == StRun) & start_i & ~freeze_i & ~clear_i;
   assign pc_same   = (pc_i == pc_q);
   assign limit_hit = count_en && (cycle_limit_i != '0) && (cnt_nxt[0] == cycle_limit_i);
   assign halt_hit  = count_en && (HALT_LIMIT != 0) && pc_same &&
                      (halt_cnt_q == HC_W'(HALT_LIMIT - 1));
   assign inc_vec   = {evt_i, 1'b1} & {NCNT{count_en}};

   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
         .inc_i     (inc_vec[g]),
         .clr_i     (clear_i),
         .cnt_o     (cnt_cur[g]),
         .cnt_nxt_o (cnt_nxt[g]),
         .ovf_o     (ovf_o[g])
      );
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      halt_cnt_d = halt_cnt_q;
      cause_d    = cause_q;
      if (clear_i) begin
         state_d    = StIdle;
         halt_cnt_d = '0;
         cause_d    = CAUSE_NONE;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d    = StRun;
                  halt_cnt_d = '0;
               end
            end
            StRun: begin
               if (!start_i) begin
                  state_d = StIdle;
               end else if (freeze_i) begin
                  state_d = StFrozen;
               end else begin
                  pc_d       = pc_i;
                  halt_cnt_d = pc_same ? halt_cnt_q + HC_W'(1) : '0;
                  if (limit_hit || halt_hit) begin
                     state_d = StDone;
                     cause_d = {halt_hit, limit_hit};
                  end
               end
            end
            StFrozen: begin
               if (!start_i) begin
                  state_d = StIdle;
               end else if (!freeze_i) begin
                  state_d = StRun;
               end
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   // Readout shows the selected counter as it stands after this edge's update.
   always_comb begin
      rd_data_d = '0;
      for (int unsigned k = 0; k < NCNT; k++) begin
         if (rd_sel_i == SEL_W'(k)) begin
            rd_data_d = cnt_nxt[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         halt_cnt_q <= '0;
         cause_q    <= CAUSE_NONE;
         rd_data_q  <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         halt_cnt_q <= halt_cnt_d;
         cause_q    <= cause_d;
         rd_data_q  <= rd_data_d;
         running_q  <= (state_d == StRun);
         done_q     <= (state_d == StDone);
      end
   end

   assign rd_data_o    = rd_data_q;
   assign cycle_cnt_o  = cnt_cur[0];
   assign running_o    = running_q;
   assign done_o       = done_q;
   assign done_cause_o = cause_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: a 32-bit saturating instance plus 4-bit saturating and
// wrapping instances share one stimulus stream and are checked against a run-level model.
module tb_pipe_perf_monitor;

   localparam int NI = 3;
   localparam int NE = 4;
   localparam int NC = NE + 1;
   localparam int HL = 8;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_FRZ  = 2;
   localparam int M_DONE = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, freeze, clear;
   logic [3:0]  evt;
   logic [31:0] pc;
   logic [31:0] limit;
   logic [2:0]  rd_sel;
   bit          pc_auto;

   logic [31:0] rd0, cc0;
   logic [4:0]  ovf0;
   logic        run0, dn0;
   logic [1:0]  cs0;
   logic [3:0]  rd1, cc1;
   logic [4:0]  ovf1;
   logic        run1, dn1;
   logic [1:0]  cs1;
   logic [3:0]  rd2, cc2;
   logic [4:0]  ovf2;
   logic        run2, dn2;
   logic [1:0]  cs2;

   int total = 0;
   int bad   = 0;

   int     st    [NI];
   longint cnt   [NI][NC];
   bit     ovfm  [NI][NC];
   int     hc    [NI];
   longint pcq   [NI];
   int     cause [NI];
   longint rdv   [NI];

   always #5 clk = ~clk;

   pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .PC_W(32), .HALT_LIMIT(8), .SATURATE(1'b1))
   u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
      .evt_i(evt), .pc_i(pc), .cycle_limit_i(limit), .rd_sel_i(rd_sel), .rd_data_o(rd0),
      .cycle_cnt_o(cc0), .ovf_o(ovf0), .running_o(run0), .done_o(dn0), .done_cause_o(cs0)
   );

   pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .PC_W(32), .HALT_LIMIT(8), .SATURATE(1'b1))
   u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
      .evt_i(evt), .pc_i(pc), .cycle_limit_i(limit[3:0]), .rd_sel_i(rd_sel), .rd_data_o(rd1),
      .cycle_cnt_o(cc1), .ovf_o(ovf1), .running_o(run1), .done_o(dn1), .done_cause_o(cs1)
   );

   pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .PC_W(32), .HALT_LIMIT(8), .SATURATE(1'b0))
   u_dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .freeze_i(freeze), .clear_i(clear),
      .evt_i(evt), .pc_i(pc), .cycle_limit_i(limit[3:0]), .rd_sel_i(rd_sel), .rd_data_o(rd2),
      .cycle_cnt_o(cc2), .ovf_o(ovf2), .running_o(run2), .done_o(dn2), .done_cause_o(cs2)
   );

   function automatic longint msk(int i);
      return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_000F;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         st[i]    = M_IDLE;
         hc[i]    = 0;
         pcq[i]   = 0;
         cause[i] = 0;
         rdv[i]   = 0;
         for (int c = 0; c < NC; c++) begin
            cnt[i][c]  = 0;
            ovfm[i][c] = 1'b0;
         end
      end
   endtask

   task automatic bump(int i, int c);
      if (cnt[i][c] == msk(i)) begin
         ovfm[i][c] = 1'b1;
         if (i == 2) cnt[i][c] = 0;
      end else begin
         cnt[i][c] = cnt[i][c] + 1;
      end
   endtask

   task automatic model_step();
      longint m, lm;
      bit     lim, hlt, eq;
      for (int i = 0; i < NI; i++) begin
         m  = msk(i);
         lm = longint'(limit) & m;
         if (clear) begin
            st[i]    = M_IDLE;
            hc[i]    = 0;
            cause[i] = 0;
            for (int c = 0; c < NC; c++) begin
               cnt[i][c]  = 0;
               ovfm[i][c] = 1'b0;
            end
         end else if (st[i] == M_IDLE) begin
            if (start) begin
               st[i] = M_RUN;
               hc[i] = 0;
            end
         end else if (st[i] == M_FRZ) begin
            if (!start) st[i] = M_IDLE;
            else if (!freeze) st[i] = M_RUN;
         end else if (st[i] == M_RUN) begin
            if (!start) begin
               st[i] = M_IDLE;
            end else if (freeze) begin
               st[i] = M_FRZ;
            end else begin
               eq  = (longint'(pc) == pcq[i]);
               lim = (lm != 0) && (((cnt[i][0] + 1) & m) == lm);
               hlt = eq && (hc[i] == HL - 1);
               hc[i]  = eq ? hc[i] + 1 : 0;
               pcq[i] = longint'(pc);
               bump(i, 0);
               for (int k = 0; k < NE; k++) if (evt[k]) bump(i, k + 1);
               if (lim || hlt) begin
                  st[i]    = M_DONE;
                  cause[i] = (hlt ? 2 : 0) + (lim ? 1 : 0);
               end
            end
         end
         rdv[i] = (rd_sel <= 3'(NE)) ? cnt[i][rd_sel] : 0;
      end
   endtask

   task automatic cmp_inst(int i, longint rd, longint cc, longint ov, bit r, bit d, longint cs);
      longint ovm;
      ovm = 0;
      for (int c = 0; c < NC; c++) if (ovfm[i][c]) ovm = ovm | (longint'(1) << c);
      chk($sformatf("rd_data[%0d]", i), rd, rdv[i]);
      chk($sformatf("cycle_cnt[%0d]", i), cc, cnt[i][0]);
      chk($sformatf("ovf[%0d]", i), ov, ovm);
      chk($sformatf("running[%0d]", i), longint'(r), longint'(st[i] == M_RUN));
      chk($sformatf("done[%0d]", i), longint'(d), longint'(st[i] == M_DONE));
      chk($sformatf("cause[%0d]", i), cs, longint'(cause[i]));
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) if (rst_n) model_step();

   always @(negedge clk) begin
      cmp_inst(0, longint'(rd0), longint'(cc0), longint'(ovf0), run0, dn0, longint'(cs0));
      cmp_inst(1, longint'(rd1), longint'(cc1), longint'(ovf1), run1, dn1, longint'(cs1));
      cmp_inst(2, longint'(rd2), longint'(cc2), longint'(ovf2), run2, dn2, longint'(cs2));
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (pc_auto) pc = pc + 32'd4;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; freeze = 1'b0; clear = 1'b0; evt = 4'h0;
      pc = 32'h100; limit = 32'd0; rd_sel = 3'd0; pc_auto = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("rst_running", longint'(run0), 0);
      chk("rst_done", longint'(dn0), 0);
      chk("rst_cycle", longint'(cc0), 0);
      chk("rst_rd", longint'(rd0), 0);
      chk("rst_ovf", longint'(ovf0), 0);
      chk("rst_cause", longint'(cs0), 0);

      // Cycle limit of 10, channel 0 on odd counted cycles.
      limit = 32'd10; start = 1'b1;
      tick();
      for (int n = 1; n <= 10; n++) begin
         evt = (n % 2 == 1) ? 4'b0001 : 4'b0000;
         tick();
         if (n == 9) chk("limit_not_yet", longint'(dn0), 0);
      end
      evt = 4'h0;
      chk("limit_done", longint'(dn0), 1);
      chk("limit_cycle", longint'(cc0), 10);
      chk("limit_cause", longint'(cs0), 1);
      rd_sel = 3'd1;
      tick();
      chk("limit_ch0", longint'(rd0), 5);

      // Halt loop: PC steps by 4 up to 0x20 then holds.
      limit = 32'd0; clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      pc_auto = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         pc = (k <= 8) ? 32'(4 * k) : 32'h20;
         tick();
         if (k == 15) chk("halt_not_yet", longint'(dn0), 0);
      end
      chk("halt_done", longint'(dn0), 1);
      chk("halt_cycle", longint'(cc0), 16);
      chk("halt_cause", longint'(cs0), 2);

      // Limit and halt on the same edge.
      clear = 1'b1;
      tick();
      clear = 1'b0; limit = 32'd16;
      tick();
      for (int k = 1; k <= 16; k++) begin
         pc = (k <= 8) ? 32'(4 * k) : 32'h20;
         tick();
      end
      chk("both_cause", longint'(cs0), 3);
      chk("both_cause_narrow", longint'(cs1), 2);

      // Overflow on the 4-bit instances: channel 1 high for 20 counted cycles.
      pc = 32'h400; pc_auto = 1'b1; limit = 32'd0; clear = 1'b1;
      tick();
      clear = 1'b0; rd_sel = 3'd2;
      tick();
      evt = 4'b0010;
      repeat (20) tick();
      evt = 4'h0; start = 1'b0;
      tick();
      chk("ovf_wide_ch1", longint'(rd0), 20);
      chk("ovf_sat_ch1", longint'(rd1), 15);
      chk("ovf_wrap_ch1", longint'(rd2), 4);
      chk("ovf_sat_flag", longint'(ovf1[2]), 1);
      chk("ovf_wrap_flag", longint'(ovf2[2]), 1);
      chk("ovf_wrap_cycle", longint'(cc2), 4);
      chk("ovf_wide_none", longint'(ovf0), 0);

      // Freeze for 3 cycles mid-run with all events high.
      clear = 1'b1;
      tick();
      clear = 1'b0; start = 1'b1;
      tick();
      evt = 4'hF;
      repeat (5) tick();
      freeze = 1'b1;
      repeat (3) tick();
      chk("frz_hold", longint'(cc0), 5);
      freeze = 1'b0;
      tick();
      chk("frz_resume", longint'(cc0), 5);
      repeat (4) tick();
      chk("frz_total", longint'(cc0), 9);
      start = 1'b0; rd_sel = 3'd4;
      tick();
      chk("frz_ch3", longint'(rd0), 9);

      // Distinct counts per channel, then sweep the readout select.
      evt = 4'h0; clear = 1'b1;
      tick();
      clear = 1'b0; start = 1'b1;
      tick();
      for (int n = 1; n <= 6; n++) begin
         for (int k = 0; k < NE; k++) evt[k] = (n <= k + 1);
         tick();
      end
      evt = 4'h0; start = 1'b0; rd_sel = 3'd0;
      tick();
      chk("sweep_sel0", longint'(rd0), 6);
      for (int s = 1; s <= NE; s++) begin
         rd_sel = 3'(s);
         tick();
         chk($sformatf("sweep_sel%0d", s), longint'(rd0), longint'(s));
      end

      // Clear wins over start and events.
      start = 1'b1;
      tick();
      evt = 4'hF;
      repeat (3) tick();
      clear = 1'b1;
      tick();
      chk("clr_running", longint'(run0), 0);
      chk("clr_cycle", longint'(cc0), 0);
      chk("clr_rd", longint'(rd0), 0);
      clear = 1'b0; start = 1'b0; evt = 4'h0;
      tick();
      chk("clr_idle_cycle", longint'(cc0), 0);
      chk("clr_idle_running", longint'(run0), 0);

      // Asynchronous reset between edges.
      start = 1'b1;
      tick();
      evt = 4'hF;
      repeat (3) tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cycle", longint'(cc0), 0);
      chk("arst_running", longint'(run0), 0);
      chk("arst_rd", longint'(rd0), 0);
      chk("arst_ovf", longint'(ovf0), 0);
      chk("arst_narrow_cycle", longint'(cc1), 0);
      start = 1'b0; evt = 4'h0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_cycle", longint'(cc0), 0);
      chk("post_rst_running", longint'(run0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
